// File: rtl/eth_rx_cmd_filter.sv
// eth_rx_cmd_filter: strips the Ethernet header and forwards payload of frames addressed to this FPGA
module eth_rx_cmd_filter #(
  parameter logic [47:0] FPGA_MAC_ADDR    = 48'h5a0102030405,
  parameter bit          ACCEPT_BROADCAST = 1'b1,
  parameter int          CNT_WIDTH        = 16
) (
  input  logic                 gtx_clk_bufg,
  input  logic                 gtx_resetn,
  input  logic [7:0]           s_axis_tdata,
  input  logic                 s_axis_tvalid,
  input  logic                 s_axis_tlast,
  input  logic                 s_axis_tuser,
  output logic                 s_axis_tready,
  output logic [7:0]           m_axis_tdata,
  output logic                 m_axis_tvalid,
  output logic                 m_axis_tlast,
  output logic                 m_axis_tuser,
  input  logic                 m_axis_tready,
  output logic [47:0]          src_mac,
  output logic [15:0]          eth_len_type,
  output logic                 hdr_valid,
  output logic [CNT_WIDTH-1:0] frames_accepted,
  output logic [CNT_WIDTH-1:0] frames_dropped,
  output logic                 frame_error
);
  typedef enum logic [1:0] {HDR, PAYLOAD, DROP} state_t;
  state_t state_q, state_d;
  logic [3:0] idx;
  logic uc_m, bc_m;
  logic [47:0] src_sh;
  logic [7:0] lt_hi;
  logic [7:0] exp_byte;
  logic s_hs, in_hdr, hdr_last, match, load, drop_end;
  assign exp_byte = 8'(FPGA_MAC_ADDR >> (6'd40 - {idx[2:0], 3'b000}));
  assign s_axis_tready = gtx_resetn & ((state_q != PAYLOAD) | m_axis_tready | ~m_axis_tvalid);
  assign s_hs = s_axis_tvalid & s_axis_tready;
  assign in_hdr = state_q == HDR;
  assign hdr_last = s_hs & in_hdr & (idx == 4'd13) & ~s_axis_tlast;
  assign match = uc_m | (ACCEPT_BROADCAST & bc_m);
  assign load = s_hs & (state_q == PAYLOAD);
  assign drop_end = s_hs & s_axis_tlast & (state_q != PAYLOAD);
  // state register
  always_ff @(posedge gtx_clk_bufg or negedge gtx_resetn)
    if (!gtx_resetn) state_q <= HDR;
    else state_q <= state_d;
  // next state: header decides forward/drop, any tlast outside HDR returns to HDR
  always_comb begin
    state_d = state_q;
    if (hdr_last) state_d = match ? PAYLOAD : DROP;
    else if (s_hs & s_axis_tlast & ~in_hdr) state_d = HDR;
  end
  // header parsing: byte index, destination match flags and shadow registers
  always_ff @(posedge gtx_clk_bufg or negedge gtx_resetn)
    if (!gtx_resetn) begin
      idx <= '0;
      uc_m <= 1'b0;
      bc_m <= 1'b0;
      src_sh <= '0;
      lt_hi <= '0;
    end else if (s_hs & in_hdr) begin
      idx <= (s_axis_tlast | (idx == 4'd13)) ? 4'd0 : idx + 4'd1;
      if (idx < 4'd6) begin
        uc_m <= ((idx == 4'd0) | uc_m) & (s_axis_tdata == exp_byte);
        bc_m <= ((idx == 4'd0) | bc_m) & (s_axis_tdata == 8'hff);
      end else if (idx < 4'd12) src_sh <= {src_sh[39:0], s_axis_tdata};
      else if (idx == 4'd12) lt_hi <= s_axis_tdata;
    end
  // publish header fields of accepted frames with a one-cycle strobe
  always_ff @(posedge gtx_clk_bufg or negedge gtx_resetn)
    if (!gtx_resetn) begin
      hdr_valid <= 1'b0;
      src_mac <= '0;
      eth_len_type <= '0;
    end else begin
      hdr_valid <= hdr_last & match;
      if (hdr_last & match) begin
        src_mac <= src_sh;
        eth_len_type <= {lt_hi, s_axis_tdata};
      end
    end
  // single payload output register stage
  always_ff @(posedge gtx_clk_bufg or negedge gtx_resetn)
    if (!gtx_resetn) begin
      m_axis_tdata <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast <= 1'b0;
      m_axis_tuser <= 1'b0;
    end else if (load) begin
      m_axis_tdata <= s_axis_tdata;
      m_axis_tvalid <= 1'b1;
      m_axis_tlast <= s_axis_tlast;
      m_axis_tuser <= s_axis_tuser & s_axis_tlast;
    end else if (m_axis_tready) m_axis_tvalid <= 1'b0;
  // saturating frame counters and error strobe
  always_ff @(posedge gtx_clk_bufg or negedge gtx_resetn)
    if (!gtx_resetn) begin
      frames_accepted <= '0;
      frames_dropped <= '0;
      frame_error <= 1'b0;
    end else begin
      frame_error <= load & s_axis_tlast & s_axis_tuser;
      if (load & s_axis_tlast & ~&frames_accepted) frames_accepted <= frames_accepted + CNT_WIDTH'(1);
      if (drop_end & ~&frames_dropped) frames_dropped <= frames_dropped + CNT_WIDTH'(1);
    end
endmodule

// File: tb/tb_eth_rx_cmd_filter.sv
// tb_eth_rx_cmd_filter: directed self-checking bench for the receive command filter
module tb_eth_rx_cmd_filter;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic [7:0] s_tdata = '0;
  logic s_tvalid = 1'b0, s_tlast = 1'b0, s_tuser = 1'b0, m_tready = 1'b1;
  logic s_tready, m_tvalid, m_tlast, m_tuser, hdr_valid, frame_error;
  logic [7:0] m_tdata;
  logic [47:0] src_mac;
  logic [15:0] eth_len_type, frames_accepted, frames_dropped;
  logic nb_s_tready, nb_m_tvalid, nb_m_tlast, nb_m_tuser, nb_hdr_valid, nb_frame_error;
  logic [7:0] nb_m_tdata;
  logic [47:0] nb_src_mac;
  logic [15:0] nb_eth_len_type, nb_frames_accepted, nb_frames_dropped;
  int total = 0, bad = 0;
  logic [7:0] fb [0:127];
  logic [7:0] rx_d [0:127];
  logic rx_l [0:127];
  logic rx_u [0:127];
  int rx_n = 0, hv_n = 0, fe_n = 0, mv_n = 0, nbv_n = 0, rdy_low = 0, bp_err = 0, bp_low = 0;
  logic [47:0] hv_src = '0;
  logic [15:0] hv_lt = '0;
  logic bp = 1'b0, in_pl = 1'b0, mon_rdy = 1'b0;

  always #4 clk = ~clk;

  eth_rx_cmd_filter dut (
    .gtx_clk_bufg(clk), .gtx_resetn(rstn),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser),
    .s_axis_tready(s_tready),
    .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tlast(m_tlast), .m_axis_tuser(m_tuser),
    .m_axis_tready(m_tready),
    .src_mac(src_mac), .eth_len_type(eth_len_type), .hdr_valid(hdr_valid),
    .frames_accepted(frames_accepted), .frames_dropped(frames_dropped), .frame_error(frame_error)
  );

  eth_rx_cmd_filter #(.ACCEPT_BROADCAST(1'b0)) dut_nb (
    .gtx_clk_bufg(clk), .gtx_resetn(rstn),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser),
    .s_axis_tready(nb_s_tready),
    .m_axis_tdata(nb_m_tdata), .m_axis_tvalid(nb_m_tvalid), .m_axis_tlast(nb_m_tlast), .m_axis_tuser(nb_m_tuser),
    .m_axis_tready(m_tready),
    .src_mac(nb_src_mac), .eth_len_type(nb_eth_len_type), .hdr_valid(nb_hdr_valid),
    .frames_accepted(nb_frames_accepted), .frames_dropped(nb_frames_dropped), .frame_error(nb_frame_error)
  );

  // output monitor sampled mid-cycle
  always @(negedge clk) begin
    if (m_tvalid && m_tready && rx_n < 128) begin
      rx_d[rx_n] = m_tdata;
      rx_l[rx_n] = m_tlast;
      rx_u[rx_n] = m_tuser;
      rx_n++;
    end
    if (hdr_valid) begin
      hv_n++;
      hv_src = src_mac;
      hv_lt = eth_len_type;
    end
    if (frame_error) fe_n++;
    if (m_tvalid) mv_n++;
    if (nb_m_tvalid) nbv_n++;
    if (mon_rdy && !s_tready) rdy_low++;
    if (bp && in_pl) begin
      if (s_tready !== (~m_tvalid | m_tready)) bp_err++;
      if (!s_tready) bp_low++;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic build(input logic [47:0] dst, input logic [47:0] src, input logic [15:0] lt, input int n);
    for (int i = 0; i < 6; i++) begin
      fb[i] = dst[47-8*i -: 8];
      fb[6+i] = src[47-8*i -: 8];
    end
    fb[12] = lt[15:8];
    fb[13] = lt[7:0];
    for (int k = 0; k < n; k++)
      fb[14+k] = (k < 2) ? 8'h43 : (k < 4) ? 8'h57 : 8'(k * 3 + 17);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic l, input logic u);
    int g;
    logic r;
    s_tdata = b;
    s_tvalid = 1'b1;
    s_tlast = l;
    s_tuser = u;
    g = 0;
    do begin
      @(negedge clk);
      r = s_tready;
      @(posedge clk);
      #1;
      if (bp) m_tready = ~m_tready;
      g++;
    end while (!r && g < 100);
    if (!r) chk("ready_wait", {63'd0, r}, 64'd1);
  endtask

  task automatic send_raw(input int len, input logic last, input logic u);
    for (int i = 0; i < len; i++) begin
      in_pl = (i >= 14);
      send_byte(fb[i], last && i == len - 1, u && i == len - 1);
    end
    in_pl = 1'b0;
    s_tvalid = 1'b0;
    s_tlast = 1'b0;
    s_tuser = 1'b0;
  endtask

  task automatic drain();
    bp = 1'b0;
    m_tready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    rx_n = 0; hv_n = 0; fe_n = 0; mv_n = 0; nbv_n = 0; rdy_low = 0; bp_err = 0; bp_low = 0;
  endtask

  task automatic check_rx(input string tag, input int n);
    int mism;
    mism = 0;
    chk({tag, "_count"}, 64'(rx_n), 64'(n));
    for (int k = 0; k < rx_n && k < n; k++)
      if (rx_d[k] !== fb[14+k] || rx_l[k] !== (k == n - 1)) mism++;
    chk({tag, "_bytes"}, 64'(mism), 64'd0);
  endtask

  initial begin
    #3;
    chk("rst_tready_low", {63'd0, s_tready}, 64'd0);
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    @(negedge clk);
    chk("rst_tready_high", {63'd0, s_tready}, 64'd1);
    chk("rst_outs", {m_tvalid, m_tlast, m_tuser, hdr_valid, frame_error, m_tdata}, 64'd0);
    chk("rst_hdr", {src_mac, eth_len_type}, 64'd0);
    chk("rst_cnts", {frames_accepted, frames_dropped}, 64'd0);
    @(posedge clk);
    #1;

    // unicast command frame
    clear_mon();
    build(48'h5a0102030405, 48'h985aebdb066f, 16'h0026, 36);
    send_raw(50, 1'b1, 1'b0);
    drain();
    check_rx("uni", 36);
    chk("uni_first", 64'(rx_d[0]), 64'h43);
    chk("uni_src", 64'(src_mac), 64'h985aebdb066f);
    chk("uni_lt", 64'(eth_len_type), 64'h0026);
    chk("uni_hv_n", 64'(hv_n), 64'd1);
    chk("uni_hv_src", {hv_src, hv_lt}, {48'h985aebdb066f, 16'h0026});
    chk("uni_acc", 64'(frames_accepted), 64'd1);

    // wrong destination
    clear_mon();
    build(48'h5a0102030406, 48'h010203040506, 16'h0010, 10);
    mon_rdy = 1'b1;
    send_raw(24, 1'b1, 1'b0);
    mon_rdy = 1'b0;
    drain();
    chk("wd_tvalid", 64'(mv_n), 64'd0);
    chk("wd_drop", 64'(frames_dropped), 64'd1);
    chk("wd_src", 64'(src_mac), 64'h985aebdb066f);
    chk("wd_ready", 64'(rdy_low), 64'd0);
    chk("wd_acc", 64'(frames_accepted), 64'd1);

    // broadcast accepted by default instance, dropped with broadcast disabled
    clear_mon();
    build(48'hffffffffffff, 48'h112233445566, 16'h0800, 8);
    send_raw(22, 1'b1, 1'b0);
    drain();
    check_rx("bc", 8);
    chk("bc_acc", 64'(frames_accepted), 64'd2);
    chk("bc_src", 64'(src_mac), 64'h112233445566);
    chk("bc_nb_drop", 64'(nb_frames_dropped), 64'd2);
    chk("bc_nb_tvalid", 64'(nbv_n), 64'd0);

    // runt frame then a good frame
    clear_mon();
    build(48'h5a0102030405, 48'h0a0b0c0d0e0f, 16'h0004, 0);
    send_raw(10, 1'b1, 1'b0);
    drain();
    chk("runt_drop", 64'(frames_dropped), 64'd2);
    chk("runt_out", 64'(mv_n), 64'd0);
    chk("runt_hv", 64'(hv_n), 64'd0);
    build(48'h5a0102030405, 48'h0a0b0c0d0e0f, 16'h0014, 20);
    send_raw(34, 1'b1, 1'b0);
    drain();
    check_rx("post_runt", 20);
    chk("post_runt_acc", 64'(frames_accepted), 64'd3);
    chk("post_runt_src", 64'(src_mac), 64'h0a0b0c0d0e0f);

    // backpressure with toggling downstream ready
    clear_mon();
    build(48'h5a0102030405, 48'h985aebdb066f, 16'h0040, 64);
    bp = 1'b1;
    send_raw(78, 1'b1, 1'b0);
    drain();
    check_rx("bp", 64);
    chk("bp_ready_rule", 64'(bp_err), 64'd0);
    chk("bp_stalled", 64'(bp_low > 0), 64'd1);
    chk("bp_acc", 64'(frames_accepted), 64'd4);

    // errored frame
    clear_mon();
    build(48'h5a0102030405, 48'h985aebdb066f, 16'h000a, 10);
    send_raw(24, 1'b1, 1'b1);
    drain();
    check_rx("err", 10);
    chk("err_tuser_last", 64'(rx_u[9]), 64'd1);
    chk("err_tuser_mid", 64'(rx_u[8]), 64'd0);
    chk("err_pulse", 64'(fe_n), 64'd1);
    chk("err_acc", 64'(frames_accepted), 64'd5);

    // reset in the middle of a payload
    clear_mon();
    build(48'h5a0102030405, 48'h665544332211, 16'h0030, 10);
    m_tready = 1'b0;
    send_raw(15, 1'b0, 1'b0);
    chk("mid_held", {63'd0, m_tvalid}, 64'd1);
    #2 rstn = 1'b0;
    #1;
    chk("mid_rst_outs", {s_tready, m_tvalid, m_tlast, m_tuser, hdr_valid, frame_error, m_tdata}, 64'd0);
    chk("mid_rst_hdr", {src_mac, eth_len_type}, 64'd0);
    chk("mid_rst_cnts", {frames_accepted, frames_dropped}, 64'd0);
    @(posedge clk);
    #1 rstn = 1'b1;
    m_tready = 1'b1;
    @(posedge clk);
    #1;
    clear_mon();
    build(48'h5a0102030405, 48'h123456789abc, 16'h000c, 12);
    send_raw(26, 1'b1, 1'b0);
    drain();
    check_rx("after_rst", 12);
    chk("after_rst_acc", 64'(frames_accepted), 64'd1);
    chk("after_rst_src", {src_mac, eth_len_type}, {48'h123456789abc, 16'h000c});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
